// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
//   CNT_W_DEF        : default counter / half-period width
//   DEFAULT_HALF_DEF : reset half-period (100 MHz system clock -> 480 Hz)
//   half_t           : half-period type at the default width
//   calc_half()      : elaboration-time half-period from input/output frequency
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned DISP_HZ    = 480;

  localparam int unsigned CNT_W_DEF = 24;

  typedef logic [CNT_W_DEF-1:0] half_t;

  function automatic int unsigned calc_half(input int unsigned f_in,
                                            input int unsigned f_out);
    return (f_in / f_out) / 2;
  endfunction

  // 100_000_000 / 480 / 2 = 104166
  localparam int unsigned DEFAULT_HALF_DEF = calc_half(SYS_CLK_HZ, DISP_HZ);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and pending half-period, square-wave
// output and single-cycle rising-edge tick.
// Ports:
//   clk_in, reset : system clock, synchronous active-high reset
//   en            : run enable; low clears counter and output
//   sync          : phase-align request (counter/output cleared, pending applied)
//   wr_en/wr_half : accepted config write for this channel
//   pending       : a new half-period is queued and not yet applied
//   clk_out, tick : divided output and its 0->1 pulse
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  // A zero half-period would never match the counter; treat it as 1.
  localparam logic [CNT_W-1:0] RST_HALF =
    (DEFAULT_HALF == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] half_q,  half_d;
  logic [CNT_W-1:0] phalf_q, phalf_d;
  logic             pend_q,  pend_d;
  logic             clk_q,   clk_d;
  logic             tick_q,  tick_d;
  logic             wrap;

  always_comb begin
    cnt_d   = cnt_q;
    half_d  = half_q;
    phalf_d = phalf_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    wrap    = (cnt_q == half_q - CNT_W'(1));

    // Accept only happens while pend_q is clear, so it never collides with
    // the apply paths below, which all require pend_q set.
    if (wr_en) begin
      pend_d  = 1'b1;
      phalf_d = (wr_half == '0) ? CNT_W'(1) : wr_half;
    end

    if (sync || !en) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        half_d = phalf_q;
        pend_d = 1'b0;
      end
    end else if (wrap) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
      // The finished half used the old value; the new one governs the next.
      if (pend_q) begin
        half_d = phalf_q;
        pend_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q   <= '0;
      half_q  <= RST_HALF;
      phalf_q <= RST_HALF;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      phalf_q <= phalf_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pending = pend_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Holds the config decode and cfg_ready mux; each channel is a clk_div_chan.
// Ports:
//   clk_in, reset        : system clock, synchronous active-high reset
//   en[NUM_CH]           : per-channel run enable
//   cfg_valid/cfg_ready  : config handshake (transfer when both high)
//   cfg_ch, cfg_half     : target channel and new half-period
//   clk_out[NUM_CH]      : divided square waves
//   tick[NUM_CH]         : one-cycle pulse on each clk_out rise
// Optional: define CLK_DIV_SYNC_EN to add the `sync` input, which clears all
// counters/outputs and applies pending half-periods (below reset, above en).
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic              ch_hit;
  logic              accept;
  logic              sync_w;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range channel: always ready, write silently dropped.
  assign ch_hit = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  always_comb begin
    cfg_ready = 1'b1;
    if (ch_hit) begin
      cfg_ready = ~pend[cfg_ch];
    end
  end

  assign accept = cfg_valid & cfg_ready & ch_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync_w),
      .wr_en   (accept && (cfg_ch == CH_W'(i))),
      .wr_half (cfg_half),
      .pending (pend[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi. The reset half-period is
// overridden to a short value so full periods fit in a brief run.
module tb_clk_div_multi;

  localparam int unsigned DH = 20;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  en;
`ifdef CLK_DIV_SYNC_EN
  logic        sync;
`endif
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_half;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  clk_div_multi #(
    .NUM_CH      (4),
    .CNT_W       (24),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
`ifdef CLK_DIV_SYNC_EN
    .sync     (sync),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [23:0] h);
    cfg_ch    = ch;
    cfg_half  = h;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif
    step(3);
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_out got %b want 0000", clk_out); end
    n_checks++;
    if (tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick got %b want 0000", tick); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    reset = 1'b0;
  endtask

  // ch0 at the reset half-period: rises at DH, period 2*DH.
  task automatic test_default;
    logic [3:0] ec, et;
    en = 4'b0001;
    for (int k = 1; k <= 62; k++) begin
      step(1);
      ec = {3'b000, ((k / DH) % 2) == 1};
      et = {3'b000, (k % (2 * DH)) == DH};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL default_clk k=%0d got %b want %b", k, clk_out, ec); end
      n_checks++;
      if (tick !== et) begin n_fail++; $display("FAIL default_tick k=%0d got %b want %b", k, tick, et); end
    end
    en = 4'b0000;
    step(1);
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL default_off got %b want 0000", clk_out); end
  endtask

  task automatic test_program;
    logic [3:0] ec, et;
    cfg_write(2'd1, 24'd3);
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL prog_pending_ready got %b want 0", cfg_ready); end
    step(1);
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL prog_applied_ready got %b want 1", cfg_ready); end
    en = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      ec = {2'b00, ((k / 3) % 2) == 1, 1'b0};
      et = {2'b00, (k % 6) == 3, 1'b0};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL h3_clk k=%0d got %b want %b", k, clk_out, ec); end
      n_checks++;
      if (tick !== et) begin n_fail++; $display("FAIL h3_tick k=%0d got %b want %b", k, tick, et); end
    end
    en = 4'b0000;
    step(1);
    // H = 0 behaves as H = 1: clk_in / 2.
    cfg_write(2'd2, 24'd0);
    step(1);
    en = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      ec = {1'b0, (k % 2) == 1, 2'b00};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL h0_clk k=%0d got %b want %b", k, clk_out, ec); end
      n_checks++;
      if (tick !== ec) begin n_fail++; $display("FAIL h0_tick k=%0d got %b want %b", k, tick, ec); end
    end
    en = 4'b0000;
    step(1);
  endtask

  // ch1 at H=5, rewritten to 2 mid-half; a second write while pending is dropped.
  task automatic test_reprogram;
    logic [3:0] ec;
    cfg_write(2'd1, 24'd5);
    step(1);
    en = 4'b0010;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      ec = {2'b00, (k >= 5) && (((k - 5) / 2) % 2 == 0), 1'b0};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL reprog_clk k=%0d got %b want %b", k, clk_out, ec); end
      if (k == 2) begin
        cfg_ch = 2'd1; cfg_half = 24'd2; cfg_valid = 1'b1;
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reprog_ready_idle got %b want 1", cfg_ready); end
      end
      if (k == 3) begin
        n_checks++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reprog_ready_pend got %b want 0", cfg_ready); end
        cfg_half = 24'd7;
      end
      if (k == 4) begin
        n_checks++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reprog_ready_held got %b want 0", cfg_ready); end
        cfg_valid = 1'b0;
      end
      if (k == 5) begin
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reprog_ready_applied got %b want 1", cfg_ready); end
      end
    end
  endtask

  // ch1 (H=2) is high here; disabling clears it and the counter.
  task automatic test_enable_toggle;
    en = 4'b0000;
    step(1);
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL dis_clk got %b want 0000", clk_out); end
    n_checks++;
    if (tick !== 4'b0000) begin n_fail++; $display("FAIL dis_tick got %b want 0000", tick); end
    step(2);
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL dis_hold got %b want 0000", clk_out); end
    en = 4'b0010;
    step(1);
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL reen_k1 got %b want 0000", clk_out); end
    step(1);
    n_checks++;
    if (clk_out !== 4'b0010) begin n_fail++; $display("FAIL reen_k2_clk got %b want 0010", clk_out); end
    n_checks++;
    if (tick !== 4'b0010) begin n_fail++; $display("FAIL reen_k2_tick got %b want 0010", tick); end
    step(1);
    n_checks++;
    if (tick !== 4'b0000) begin n_fail++; $display("FAIL reen_k3_tick got %b want 0000", tick); end
    en = 4'b0000;
    step(1);
  endtask

  task automatic test_reset_pending;
    logic [3:0] ec;
    en = 4'b1000;
    step(2);
    cfg_write(2'd3, 24'd4);
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_pend got %b want 0", cfg_ready); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL rstp_clk got %b want 0000", clk_out); end
    n_checks++;
    if (tick !== 4'b0000) begin n_fail++; $display("FAIL rstp_tick got %b want 0000", tick); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready got %b want 1", cfg_ready); end
    // The discarded H=4 would rise at k=4; the default rises at k=DH.
    for (int k = 1; k <= DH; k++) begin
      step(1);
      ec = {(k >= DH), 3'b000};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL rstp_run k=%0d got %b want %b", k, clk_out, ec); end
    end
    en = 4'b0000;
    step(1);
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync;
    logic [3:0] ec, et;
    cfg_write(2'd0, 24'd5);
    cfg_write(2'd1, 24'd3);
    step(1);
    en = 4'b0011;
    step(1);
    // Queued on ch0 mid-half; sync must apply it at once.
    cfg_write(2'd0, 24'd2);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    n_checks++;
    if (clk_out !== 4'b0000) begin n_fail++; $display("FAIL sync_clk got %b want 0000", clk_out); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sync_applied got %b want 1", cfg_ready); end
    for (int k = 1; k <= 14; k++) begin
      step(1);
      ec = {2'b00, ((k / 3) % 2) == 1, ((k / 2) % 2) == 1};
      et = {2'b00, (k % 6) == 3, (k % 4) == 2};
      n_checks++;
      if (clk_out !== ec) begin n_fail++; $display("FAIL sync_run_clk k=%0d got %b want %b", k, clk_out, ec); end
      n_checks++;
      if (tick !== et) begin n_fail++; $display("FAIL sync_run_tick k=%0d got %b want %b", k, tick, et); end
    end
    en = 4'b0000;
    step(1);
  endtask
`endif

  initial begin
    test_reset;
    test_default;
    test_program;
    test_reprogram;
    test_enable_toggle;
    test_reset_pending;
`ifdef CLK_DIV_SYNC_EN
    test_sync;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
